// File: rtl/feature_buffer_pkg.sv
// -----------------------------------------------------------------------------
// feature_buffer_pkg
// Shared definitions for the feature-buffer bus responder:
//   - FSM state encoding (state_t)
//   - custom-instruction opcodes carried on ciValueA
//   - sat_add(): saturating 32-bit counter increment
// No ports (package).
// -----------------------------------------------------------------------------
package feature_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [31:0] CI_READ_WORD   = 32'd0;
    localparam logic [31:0] CI_READ_WORDS  = 32'd1;
    localparam logic [31:0] CI_READ_ERRORS = 32'd2;
    localparam logic [31:0] CI_CLEAR       = 32'd3;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] value, input logic [1:0] amount);
        logic [32:0] sum;
        sum = {1'b0, value} + {31'd0, amount};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/feature_buffer_target_if.sv
// -----------------------------------------------------------------------------
// feature_buffer_target_if
// Burst-write bus between the feature-transfer DMA (master) and the feature
// buffer (slave).
//   beginTransactionIn  one-cycle burst start; addressDataIn = start address,
//                       burstSizeIn = beats-1
//   addressDataIn       address (begin cycle) or write data (beat cycles)
//   burstSizeIn         beats minus 1
//   byteEnablesIn       per-beat byte enables
//   dataValidIn         write beat present
//   endTransactionIn    one-cycle burst end
//   busyOut             wait state from the slave; master holds the beat
//   busErrorOut         burst rejected
// -----------------------------------------------------------------------------
interface feature_buffer_target_if;
    import feature_buffer_pkg::*;

    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busyOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn,
        output addressDataIn,
        output burstSizeIn,
        output byteEnablesIn,
        output dataValidIn,
        output endTransactionIn,
        input  busyOut,
        input  busErrorOut
    );

    modport slave (
        input  beginTransactionIn,
        input  addressDataIn,
        input  burstSizeIn,
        input  byteEnablesIn,
        input  dataValidIn,
        input  endTransactionIn,
        output busyOut,
        output busErrorOut
    );

endinterface

// File: rtl/feature_buffer_ram.sv
// -----------------------------------------------------------------------------
// feature_buffer_ram
// DEPTH x 32 storage, one byte-enabled write port and one registered read
// port. A read and write of the same word in one cycle returns the old word.
// Contents are not reset.
//   sysClock    clock
//   write_en    write strobe
//   write_addr  word address
//   write_be    byte enables, bit i -> byte [8i+7:8i]
//   write_data  write word
//   read_en     read strobe; read_data updates on the next edge
//   read_addr   word address
//   read_data   registered read word
// -----------------------------------------------------------------------------
module feature_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sysClock,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [3:0]    write_be,
    input  logic [31:0]   write_data,
    input  logic          read_en,
    input  logic [AW-1:0] read_addr,
    output logic [31:0]   read_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge sysClock) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (write_be[b]) begin
                    mem[write_addr][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
        if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/feature_buffer_target.sv
// -----------------------------------------------------------------------------
// feature_buffer_target
// Slave end of the DMA burst-write bus. Accepts bursts into a DEPTH-word
// window starting at BASE_ADDRESS, rejects illegal/overrun bursts with
// busErrorOut, and exposes buffer words and beat/error counters to the CPU via
// a custom instruction.
//
// Optional feature macro: FEATURE_BUFFER_WAIT_STATES_EN
//   defined   -> one busyOut cycle after every WAIT_PERIOD accepted beats
//   undefined -> busyOut tied 0
//
// Ports
//   sysClock, reset   clock; synchronous active-high reset
//   bus               feature_buffer_target_if.slave burst-write bus
//   ciStart, ciCke    custom-instruction strobe and clock enable
//   ciN               instruction id (answers CUSTOM_INSTRUCTION_ID)
//   ciValueA          opcode (feature_buffer_pkg CI_*)
//   ciValueB          operand (word index for CI_READ_WORD)
//   ciResult          result, 0 while ciDone is low
//   ciDone            one-cycle completion, one cycle after the strobe
//   frameWritten      one-cycle pulse after an error-free burst end
//
// State    | meaning
// ST_IDLE  | waiting for beginTransactionIn
// ST_DATA  | legal burst open, accepting beats
// ST_ERROR | burst rejected, busErrorOut held until end
// -----------------------------------------------------------------------------
module feature_buffer_target
    import feature_buffer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS          = 32'h0000_AB00,
    parameter int          DEPTH                 = 64,
    parameter int          CUSTOM_INSTRUCTION_ID = 43,
    parameter int          WAIT_PERIOD           = 4
) (
    input  logic                   sysClock,
    input  logic                   reset,
    feature_buffer_target_if.slave bus,
    input  logic                   ciStart,
    input  logic                   ciCke,
    input  logic [7:0]             ciN,
    input  logic [31:0]            ciValueA,
    input  logic [31:0]            ciValueB,
    output logic [31:0]            ciResult,
    output logic                   ciDone,
    output logic                   frameWritten
);

    localparam int              AW          = $clog2(DEPTH);
    localparam logic [32:0]     DEPTH_WORDS = 33'(DEPTH);
    localparam logic [7:0]      CI_ID       = 8'(CUSTOM_INSTRUCTION_ID);
    localparam logic [AW-1:0]   IDX_ONE     = AW'(1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] idx;
    logic [8:0]    remaining;
    logic [8:0]    remaining_after;
    logic [31:0]   word_count;
    logic [31:0]   error_count;
    logic          frame_q;
    logic          bus_error_q;
    logic          busy;

    logic          load;
    logic [1:0]    err_inc;
    logic          frame_set;
    logic          err_hold;

    logic          ci_fire;
    logic          ci_read;
    logic          ci_clear;
    logic [31:0]   ci_value;
    logic          ci_done_q;
    logic          read_sel_q;
    logic [31:0]   result_q;
    logic [31:0]   ram_rdata;

    // Window check: offset computed modulo 2^32, only meaningful when the
    // address is at or above the base, which is part of the same check.
    logic [31:0] offset;
    logic [32:0] span;
    logic        legal;

    assign offset = bus.addressDataIn - BASE_ADDRESS;
    assign span   = {3'd0, offset[31:2]} + {25'd0, bus.burstSizeIn} + 33'd1;
    assign legal  = (bus.addressDataIn[1:0] == 2'b00)
                 && (bus.addressDataIn >= BASE_ADDRESS)
                 && (span <= DEPTH_WORDS);

    // A begin cycle carries an address, never data. Reset abandons the beat
    // presented in the same cycle.
    logic beat;
    logic accept;
    logic overrun;

    assign beat    = (state == ST_DATA) && bus.dataValidIn && !busy
                  && !bus.beginTransactionIn && !reset;
    assign accept  = beat && (remaining != 9'd0);
    assign overrun = beat && (remaining == 9'd0);
    assign remaining_after = accept ? (remaining - 9'd1) : remaining;

    always_ff @(posedge sysClock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        err_inc    = 2'd0;
        frame_set  = 1'b0;
        err_hold   = 1'b0;

        if (bus.beginTransactionIn) begin
            // A begin outside IDLE counts as a violation, then restarts.
            load    = 1'b1;
            err_inc = (state != ST_IDLE) ? 2'd1 : 2'd0;
            if (legal) begin
                state_next = ST_DATA;
            end else begin
                state_next = ST_ERROR;
                err_inc    = err_inc + 2'd1;
            end
        end else begin
            case (state)
                ST_DATA: begin
                    if (overrun) begin
                        err_inc = 2'd1;
                        if (bus.endTransactionIn) begin
                            state_next = ST_IDLE;
                            err_hold   = 1'b1;
                        end else begin
                            state_next = ST_ERROR;
                        end
                    end else if (bus.endTransactionIn) begin
                        state_next = ST_IDLE;
                        if (remaining_after == 9'd0) begin
                            frame_set = 1'b1;
                        end else begin
                            err_inc = 2'd1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (bus.endTransactionIn) begin
                        state_next = ST_IDLE;
                        err_hold   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ci_fire  = ciStart && ciCke && (ciN == CI_ID);
    assign ci_read  = ci_fire && (ciValueA == CI_READ_WORD);
    assign ci_clear = ci_fire && (ciValueA == CI_CLEAR);

    always_comb begin
        ci_value = 32'd0;
        case (ciValueA)
            CI_READ_WORDS:  ci_value = word_count;
            CI_READ_ERRORS: ci_value = error_count;
            default:        ci_value = 32'd0;
        endcase
    end

    always_ff @(posedge sysClock) begin
        if (reset) begin
            idx         <= '0;
            remaining   <= 9'd0;
            word_count  <= 32'd0;
            error_count <= 32'd0;
            frame_q     <= 1'b0;
            bus_error_q <= 1'b0;
            ci_done_q   <= 1'b0;
            read_sel_q  <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            if (load) begin
                idx       <= offset[AW+1:2];
                remaining <= {1'b0, bus.burstSizeIn} + 9'd1;
            end else if (accept) begin
                idx       <= idx + IDX_ONE;
                remaining <= remaining - 9'd1;
            end

            // Clear wins over the old value but not over same-cycle events.
            if (ci_clear) begin
                word_count  <= {31'd0, accept};
                error_count <= {30'd0, err_inc};
            end else begin
                word_count  <= sat_add(word_count, {1'b0, accept});
                error_count <= sat_add(error_count, err_inc);
            end

            frame_q     <= frame_set;
            bus_error_q <= (state_next == ST_ERROR) || err_hold;
            ci_done_q   <= ci_fire;
            read_sel_q  <= ci_read;
            result_q    <= ci_fire ? ci_value : 32'd0;
        end
    end

    feature_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .sysClock   (sysClock),
        .write_en   (accept),
        .write_addr (idx),
        .write_be   (bus.byteEnablesIn),
        .write_data (bus.addressDataIn),
        .read_en    (ci_read),
        .read_addr  (ciValueB[AW-1:0]),
        .read_data  (ram_rdata)
    );

`ifdef FEATURE_BUFFER_WAIT_STATES_EN
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_PERIOD - 1);

    logic [15:0] wait_count;
    logic        busy_q;

    always_ff @(posedge sysClock) begin
        if (reset || load) begin
            wait_count <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            if (accept) begin
                if (wait_count == WAIT_LAST) begin
                    wait_count <= 16'd0;
                    busy_q     <= 1'b1;
                end else begin
                    wait_count <= wait_count + 16'd1;
                end
            end
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    assign bus.busyOut     = busy;
    assign bus.busErrorOut = bus_error_q;
    assign frameWritten    = frame_q;
    assign ciDone          = ci_done_q;
    assign ciResult        = ci_done_q ? (read_sel_q ? ram_rdata : result_q) : 32'd0;

    logic unused_bits;
    assign unused_bits = ^{ciValueB[31:AW], offset[1:0], (WAIT_PERIOD != 0)};

endmodule

// File: tb/tb_feature_buffer_target.sv
module tb_feature_buffer_target;
    import feature_buffer_pkg::*;

    logic        sysClock = 1'b0;
    logic        reset;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        frameWritten;

    feature_buffer_target_if bus_if();

    feature_buffer_target dut (
        .sysClock     (sysClock),
        .reset        (reset),
        .bus          (bus_if),
        .ciStart      (ciStart),
        .ciCke        (ciCke),
        .ciN          (ciN),
        .ciValueA     (ciValueA),
        .ciValueB     (ciValueB),
        .ciResult     (ciResult),
        .ciDone       (ciDone),
        .frameWritten (frameWritten)
    );

    always #5 sysClock = ~sysClock;

    int checks = 0;
    int errors = 0;
    int frame_count = 0;
    int busy_count = 0;

    always @(negedge sysClock) begin
        if (frameWritten) frame_count++;
        if (bus_if.busyOut) busy_count++;
    end

    typedef struct {
        int          phase;
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } ci_vec_t;

    ci_vec_t tbl[$];

    function automatic ci_vec_t v(input int phase, input string name,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp);
        ci_vec_t r;
        r.phase = phase; r.name = name; r.a = a; r.b = b; r.exp = exp;
        return r;
    endfunction

    task automatic tick();
        @(posedge sysClock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic ci_check(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd43; ciValueA = a; ciValueB = b;
        tick();
        ciStart = 1'b0;
        check({name, ".done"}, 32'(ciDone), 32'd1);
        check(name, ciResult, exp);
    endtask

    task automatic run_table(input int phase);
        foreach (tbl[i]) begin
            if (tbl[i].phase == phase) ci_check(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].exp);
        end
    endtask

    task automatic begin_burst(input logic [31:0] addr, input logic [7:0] size);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = addr;
        bus_if.burstSizeIn        = size;
        tick();
        bus_if.beginTransactionIn = 1'b0;
    endtask

    // Holds the beat while busyOut is high; busyOut seen now applies to the coming edge.
    task automatic beat(input logic [31:0] data, input logic [3:0] be);
        int   tries;
        logic accepted;
        tries = 0;
        accepted = 1'b0;
        bus_if.dataValidIn   = 1'b1;
        bus_if.addressDataIn = data;
        bus_if.byteEnablesIn = be;
        while (!accepted && tries < 4) begin
            accepted = !bus_if.busyOut;
            tick();
            tries++;
        end
        bus_if.dataValidIn = 1'b0;
        check("beat_accept", 32'(accepted), 32'd1);
    endtask

    task automatic end_burst(input string name, input logic exp_frame);
        bus_if.endTransactionIn = 1'b1;
        tick();
        bus_if.endTransactionIn = 1'b0;
        check({name, ".frame"}, 32'(frameWritten), 32'(exp_frame));
        tick();
        check({name, ".frame_off"}, 32'(frameWritten), 32'd0);
    endtask

    task automatic err_burst(input string name, input logic [31:0] addr, input logic [7:0] size);
        begin_burst(addr, size);
        check({name, ".err_entry"}, 32'(bus_if.busErrorOut), 32'd1);
        bus_if.dataValidIn = 1'b1; bus_if.addressDataIn = 32'hDEAD_BEEF; bus_if.byteEnablesIn = 4'hF;
        tick();
        bus_if.dataValidIn = 1'b0;
        check({name, ".err_held"}, 32'(bus_if.busErrorOut), 32'd1);
        bus_if.endTransactionIn = 1'b1;
        tick();
        bus_if.endTransactionIn = 1'b0;
        check({name, ".err_after_end"}, 32'(bus_if.busErrorOut), 32'd1);
        tick();
        check({name, ".err_clear"}, 32'(bus_if.busErrorOut), 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames_before;
        int exp_busy;

        // phase 0: after reset
        tbl.push_back(v(0, "rst_words",  CI_READ_WORDS,  0, 32'd0));
        tbl.push_back(v(0, "rst_errors", CI_READ_ERRORS, 0, 32'd0));
        // phase 1: first 4-beat burst
        tbl.push_back(v(1, "b1_w0",    CI_READ_WORD,   0,  32'h0000_134A));
        tbl.push_back(v(1, "b1_w1",    CI_READ_WORD,   1,  32'h0000_2468));
        tbl.push_back(v(1, "b1_w2",    CI_READ_WORD,   2,  32'h0000_AF38));
        tbl.push_back(v(1, "b1_w3",    CI_READ_WORD,   3,  32'h0000_0156));
        tbl.push_back(v(1, "b1_wrap",  CI_READ_WORD,   65, 32'h0000_2468));
        tbl.push_back(v(1, "b1_words", CI_READ_WORDS,  0,  32'd4));
        tbl.push_back(v(1, "b1_errs",  CI_READ_ERRORS, 0,  32'd0));
        tbl.push_back(v(1, "b1_other", 32'd9,          0,  32'd0));
        // phase 2: byte enables
        tbl.push_back(v(2, "be_word",  CI_READ_WORD,  4, 32'h00FF_00FF));
        tbl.push_back(v(2, "be_words", CI_READ_WORDS, 0, 32'd6));
        // phase 3: illegal bursts plus top-of-window legal one
        tbl.push_back(v(3, "ill_errs",   CI_READ_ERRORS, 0,  32'd3));
        tbl.push_back(v(3, "ill_words",  CI_READ_WORDS,  0,  32'd7));
        tbl.push_back(v(3, "ill_w3",     CI_READ_WORD,   3,  32'h0000_0156));
        tbl.push_back(v(3, "top_w63",    CI_READ_WORD,   63, 32'h5555_AAAA));
        tbl.push_back(v(3, "clr",        CI_CLEAR,       0,  32'd0));
        tbl.push_back(v(3, "clr_words",  CI_READ_WORDS,  0,  32'd0));
        tbl.push_back(v(3, "clr_errs",   CI_READ_ERRORS, 0,  32'd0));
        // phase 4: overrun, short burst, begin-in-DATA
        tbl.push_back(v(4, "p4_errs",  CI_READ_ERRORS, 0,  32'd3));
        tbl.push_back(v(4, "p4_words", CI_READ_WORDS,  0,  32'd6));
        tbl.push_back(v(4, "ov_w0",    CI_READ_WORD,   0,  32'h0000_000A));
        tbl.push_back(v(4, "ov_w1",    CI_READ_WORD,   1,  32'h0000_000B));
        tbl.push_back(v(4, "ov_w2",    CI_READ_WORD,   2,  32'h0000_AF38));
        tbl.push_back(v(4, "sh_w16",   CI_READ_WORD,   16, 32'h0000_0016));
        tbl.push_back(v(4, "sh_w17",   CI_READ_WORD,   17, 32'h0000_0017));
        tbl.push_back(v(4, "pv_w20",   CI_READ_WORD,   20, 32'h0000_0020));
        tbl.push_back(v(4, "pv_w24",   CI_READ_WORD,   24, 32'h0000_0024));
        tbl.push_back(v(4, "clr2",     CI_CLEAR,       0,  32'd0));
        // phase 5: 8-beat burst (wait states when enabled)
        tbl.push_back(v(5, "ws_words", CI_READ_WORDS, 0, 32'd8));
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(5, $sformatf("ws_w%0d", 40 + i), CI_READ_WORD, 32'(40 + i), 32'h5000_0000 + 32'(i)));
        // phase 6: right after mid-burst reset
        tbl.push_back(v(6, "mr_words", CI_READ_WORDS,  0, 32'd0));
        tbl.push_back(v(6, "mr_errs",  CI_READ_ERRORS, 0, 32'd0));
        // phase 7: after post-reset burst
        tbl.push_back(v(7, "pr_w8",    CI_READ_WORD,  8,  32'h0000_0088));
        tbl.push_back(v(7, "pr_w9",    CI_READ_WORD,  9,  32'h0000_0099));
        tbl.push_back(v(7, "pr_w40",   CI_READ_WORD,  40, 32'h1111_1111));
        tbl.push_back(v(7, "pr_w41",   CI_READ_WORD,  41, 32'h5000_0001));
        tbl.push_back(v(7, "pr_w43",   CI_READ_WORD,  43, 32'h5000_0003));
        tbl.push_back(v(7, "pr_w3",    CI_READ_WORD,  3,  32'h0000_0156));
        tbl.push_back(v(7, "pr_words", CI_READ_WORDS, 0,  32'd2));

        reset = 1'b1;
        ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = 32'd0; ciValueB = 32'd0;
        bus_if.beginTransactionIn = 1'b0; bus_if.addressDataIn = 32'd0; bus_if.burstSizeIn = 8'd0;
        bus_if.byteEnablesIn = 4'h0; bus_if.dataValidIn = 1'b0; bus_if.endTransactionIn = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busErr", 32'(bus_if.busErrorOut), 32'd0);
        check("rst_busy",   32'(bus_if.busyOut),     32'd0);
        check("rst_done",   32'(ciDone),             32'd0);
        check("rst_result", ciResult,                32'd0);
        check("rst_frame",  32'(frameWritten),       32'd0);
        run_table(0);

        // basic 4-beat burst
        frames_before = frame_count;
        begin_burst(32'h0000_AB00, 8'd3);
        beat(32'h0000_134A, 4'hF);
        beat(32'h0000_2468, 4'hF);
        beat(32'h0000_AF38, 4'hF);
        beat(32'h0000_0156, 4'hF);
        end_burst("b1", 1'b1);
        check("b1_frame_count", 32'(frame_count - frames_before), 32'd1);
        run_table(1);
        tick();
        check("ci_idle_result", ciResult, 32'd0);
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd42; ciValueA = CI_READ_WORDS;
        tick();
        ciStart = 1'b0;
        check("ci_wrong_id", 32'(ciDone), 32'd0);

        // byte enables over a zeroed word, with a same-cycle CI read of that word
        begin_burst(32'h0000_AB10, 8'd0);
        beat(32'h0000_0000, 4'hF);
        end_burst("zero", 1'b1);
        begin_burst(32'h0000_AB10, 8'd0);
        bus_if.dataValidIn = 1'b1; bus_if.addressDataIn = 32'hFFFF_FFFF; bus_if.byteEnablesIn = 4'b0101;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd43; ciValueA = CI_READ_WORD; ciValueB = 32'd4;
        tick();
        bus_if.dataValidIn = 1'b0; ciStart = 1'b0;
        check("rbw.done", 32'(ciDone), 32'd1);
        check("rbw.old",  ciResult,    32'd0);
        end_burst("be", 1'b1);
        run_table(2);

        // illegal bursts
        frames_before = frame_count;
        err_burst("misaligned", 32'h0000_AB0D, 8'd1);
        err_burst("below_base", 32'h0000_AA00, 8'd1);
        err_burst("past_top",   32'h0000_ABFC, 8'd1);
        check("ill_frames", 32'(frame_count - frames_before), 32'd0);
        begin_burst(32'h0000_ABFC, 8'd0);
        check("top_noerr", 32'(bus_if.busErrorOut), 32'd0);
        beat(32'h5555_AAAA, 4'hF);
        end_burst("top", 1'b1);
        run_table(3);

        // overrun: 2-beat burst given 3 beats
        begin_burst(32'h0000_AB00, 8'd1);
        beat(32'h0000_000A, 4'hF);
        beat(32'h0000_000B, 4'hF);
        check("ov_pre", 32'(bus_if.busErrorOut), 32'd0);
        beat(32'h0000_000C, 4'hF);
        check("ov_err", 32'(bus_if.busErrorOut), 32'd1);
        end_burst("ov", 1'b0);
        check("ov_err_clear", 32'(bus_if.busErrorOut), 32'd0);
        // short: 4-beat burst given 2 beats
        begin_burst(32'h0000_AB40, 8'd3);
        beat(32'h0000_0016, 4'hF);
        beat(32'h0000_0017, 4'hF);
        end_burst("short", 1'b0);
        check("short_noerr", 32'(bus_if.busErrorOut), 32'd0);
        // begin while a burst is open
        begin_burst(32'h0000_AB50, 8'd1);
        beat(32'h0000_0020, 4'hF);
        begin_burst(32'h0000_AB60, 8'd0);
        beat(32'h0000_0024, 4'hF);
        end_burst("pv", 1'b1);
        run_table(4);

        // 8-beat burst
`ifdef FEATURE_BUFFER_WAIT_STATES_EN
        exp_busy = 2;
`else
        exp_busy = 0;
`endif
        busy_count = 0;
        begin_burst(32'h0000_ABA0, 8'd7);
        for (int i = 0; i < 8; i++) beat(32'h5000_0000 + 32'(i), 4'hF);
        end_burst("ws", 1'b1);
        check("ws_busy_cycles", 32'(busy_count), 32'(exp_busy));
        run_table(5);

        // reset during beat 2 of 4; later beats must be ignored
        begin_burst(32'h0000_ABA0, 8'd3);
        beat(32'h1111_1111, 4'hF);
        bus_if.dataValidIn = 1'b1; bus_if.addressDataIn = 32'h2222_2222; bus_if.byteEnablesIn = 4'hF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busErr", 32'(bus_if.busErrorOut), 32'd0);
        check("mr_busy",   32'(bus_if.busyOut),     32'd0);
        check("mr_frame",  32'(frameWritten),       32'd0);
        check("mr_done",   32'(ciDone),             32'd0);
        check("mr_result", ciResult,                32'd0);
        bus_if.addressDataIn = 32'h3333_3333;
        tick();
        bus_if.addressDataIn = 32'h4444_4444;
        tick();
        bus_if.dataValidIn = 1'b0;
        run_table(6);
        begin_burst(32'h0000_AB20, 8'd1);
        beat(32'h0000_0088, 4'hF);
        beat(32'h0000_0099, 4'hF);
        end_burst("pr", 1'b1);
        run_table(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
